// File: rtl/bank_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bank_arb_pkg
//  Purpose  : Shared sizing constants and types for the bank slot arbiter.
//  Revision : 1.0
// ============================================================================
package bank_arb_pkg;

    localparam int NUM_SLOTS   = 2;
    localparam int NUM_BANKS   = 5;
    localparam int ADDR_WIDTH  = 9;
    localparam int DATA_WIDTH  = 32;
    localparam int RAM_LATENCY = 2;
    localparam int SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    // Tag stage 0 loads on acceptance; the last stage lines up with ram_rdata.
    localparam int TAG_DEPTH   = RAM_LATENCY + 2;

    typedef logic [NUM_BANKS-1:0]  mask_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef data_t [NUM_BANKS-1:0] lanes_t;
    typedef logic [SLOT_W-1:0]     slot_t;

    typedef struct packed {
        logic  valid;
        slot_t slot;
        mask_t mask;
    } rd_tag_t;

    function automatic lanes_t mask_lanes(input lanes_t d, input mask_t m);
        lanes_t r;
        for (int b = 0; b < NUM_BANKS; b++) begin
            r[b] = m[b] ? d[b] : '0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bank_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module   : bank_rr_grant
//  Purpose  : Request vector to one-hot grant. Round-robin by default;
//             BANK_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
//  Revision : 1.0
// ============================================================================
module bank_rr_grant #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    logic             w_lo_found;
    logic [IDX_W-1:0] w_lo_idx;

    always_comb begin
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IDX_W'(i);
            end
        end
    end

`ifdef BANK_ARB_FIXED_PRIO_EN
    logic w_unused_ok;
    assign w_unused_ok = clk ^ rst;

    always_comb begin
        o_gnt_vld = w_lo_found;
        o_gnt_idx = w_lo_idx;
        o_gnt     = w_lo_found ? (N'(1) << w_lo_idx) : '0;
    end
`else
    logic [IDX_W-1:0] r_ptr_q;
    logic [IDX_W-1:0] w_ptr_d;
    logic             w_hi_found;
    logic [IDX_W-1:0] w_hi_idx;

    // Requesters at or above the pointer win; otherwise wrap to the lowest.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i] && (i >= int'(r_ptr_q))) begin
                w_hi_found = 1'b1;
                w_hi_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        o_gnt_vld = w_lo_found;
        o_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        o_gnt     = w_lo_found ? (N'(1) << o_gnt_idx) : '0;
        w_ptr_d   = r_ptr_q;
        if (o_gnt_vld) begin
            w_ptr_d = (o_gnt_idx == IDX_W'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/bank_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bank_slot_arbiter
//  Purpose  : Grants one slot command per cycle onto the five RAM banks and
//             routes read data back by tag. Option: BANK_ARB_FIXED_PRIO_EN.
//  Revision : 1.0
// ============================================================================
module bank_slot_arbiter
    import bank_arb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic   [NUM_SLOTS-1:0]  s_valid,
    output logic   [NUM_SLOTS-1:0]  s_ready,
    input  logic   [NUM_SLOTS-1:0]  s_rw,
    input  mask_t  [NUM_SLOTS-1:0]  s_mask,
    input  addr_t  [NUM_SLOTS-1:0]  s_addr,
    input  logic   [NUM_SLOTS-1:0]  s_wvalid,
    output logic   [NUM_SLOTS-1:0]  s_wready,
    input  lanes_t [NUM_SLOTS-1:0]  s_wdata,
    output logic   [NUM_SLOTS-1:0]  s_rvalid,
    output lanes_t [NUM_SLOTS-1:0]  s_rdata,
    output mask_t                   ram_en,
    output mask_t                   ram_we,
    output addr_t  [NUM_BANKS-1:0]  ram_addr,
    output lanes_t                  ram_wdata,
    input  lanes_t                  ram_rdata
);

    logic [NUM_SLOTS-1:0] w_elig;
    logic [NUM_SLOTS-1:0] w_gnt;
    slot_t                w_sel;
    logic                 w_acc;

    // Reset masks eligibility so no ready can leak out while rst is high.
    assign w_elig = s_valid & (~s_rw | s_wvalid) & {NUM_SLOTS{~rst}};

    bank_rr_grant #(
        .N     (NUM_SLOTS),
        .IDX_W (SLOT_W)
    ) u_grant (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_elig),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_sel),
        .o_gnt_vld (w_acc)
    );

    assign s_ready  = w_gnt;
    assign s_wready = w_gnt & s_rw;

    mask_t                 r_ram_en_q,    w_ram_en_d;
    mask_t                 r_ram_we_q,    w_ram_we_d;
    addr_t [NUM_BANKS-1:0] r_ram_addr_q,  w_ram_addr_d;
    lanes_t                r_ram_wdata_q, w_ram_wdata_d;

    always_comb begin
        w_ram_en_d    = '0;
        w_ram_we_d    = '0;
        w_ram_addr_d  = '0;
        w_ram_wdata_d = '0;
        if (w_acc) begin
            w_ram_en_d = s_mask[w_sel];
            w_ram_we_d = s_rw[w_sel] ? s_mask[w_sel] : '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (s_mask[w_sel][b]) begin
                    w_ram_addr_d[b]  = s_addr[w_sel];
                    w_ram_wdata_d[b] = s_wdata[w_sel][b];
                end
            end
        end
    end

    rd_tag_t [TAG_DEPTH-1:0] r_tag_q, w_tag_d;

    always_comb begin
        w_tag_d[0] = '0;
        if (w_acc && !s_rw[w_sel]) begin
            w_tag_d[0].valid = 1'b1;
            w_tag_d[0].slot  = w_sel;
            w_tag_d[0].mask  = s_mask[w_sel];
        end
        for (int k = 1; k < TAG_DEPTH; k++) begin
            w_tag_d[k] = r_tag_q[k-1];
        end
    end

    logic   [NUM_SLOTS-1:0] r_rvalid_q, w_rvalid_d;
    lanes_t [NUM_SLOTS-1:0] r_rdata_q,  w_rdata_d;
    rd_tag_t                w_last;

    assign w_last = r_tag_q[TAG_DEPTH-1];

    // Return data is held per slot until the next return to that slot.
    always_comb begin
        w_rvalid_d = '0;
        w_rdata_d  = r_rdata_q;
        if (w_last.valid) begin
            w_rvalid_d[w_last.slot] = 1'b1;
            w_rdata_d[w_last.slot]  = mask_lanes(ram_rdata, w_last.mask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_en_q    <= '0;
            r_ram_we_q    <= '0;
            r_ram_addr_q  <= '0;
            r_ram_wdata_q <= '0;
            r_tag_q       <= '0;
            r_rvalid_q    <= '0;
            r_rdata_q     <= '0;
        end else begin
            r_ram_en_q    <= w_ram_en_d;
            r_ram_we_q    <= w_ram_we_d;
            r_ram_addr_q  <= w_ram_addr_d;
            r_ram_wdata_q <= w_ram_wdata_d;
            r_tag_q       <= w_tag_d;
            r_rvalid_q    <= w_rvalid_d;
            r_rdata_q     <= w_rdata_d;
        end
    end

    assign ram_en    = r_ram_en_q;
    assign ram_we    = r_ram_we_q;
    assign ram_addr  = r_ram_addr_q;
    assign ram_wdata = r_ram_wdata_q;
    assign s_rvalid  = r_rvalid_q;
    assign s_rdata   = r_rdata_q;

endmodule
`default_nettype wire

// File: doc/bank_slot_arbiter.md
# bank_slot_arbiter

Shares the five-bank RAM array among NUM_SLOTS command/data requesters. Each cycle it grants at most one slot's read or write command, drives the per-bank RAM enables, and routes read data back to the originating slot after the fixed RAM latency. It sits between the slot-side Bank_Cmd/Bank_Data channels and the bank RAM macros inside the bank RAM subsystem.

## Interface
- NUM_SLOTS, 2, number of requesting slots (≥1)
- NUM_BANKS, 5, number of RAM banks (mask width)
- ADDR_WIDTH, 9, per-bank word address width
- DATA_WIDTH, 32, per-bank data lane width
- RAM_LATENCY, 2, read latency of bank RAM (cycles from sampled enable to valid ram_rdata), ≥1
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  [NUM_SLOTS]  command valid per slot
- s_ready  out  [NUM_SLOTS]  command accepted this cycle
- s_rw  in  [NUM_SLOTS]  1 = write, 0 = read
- s_mask  in  [NUM_SLOTS][NUM_BANKS]  bank enable mask
- s_addr  in  [NUM_SLOTS][ADDR_WIDTH]  address, common to all banks in mask
- s_wvalid  in  [NUM_SLOTS]  write data valid
- s_wready  out  [NUM_SLOTS]  write data accepted
- s_wdata  in  [NUM_SLOTS][NUM_BANKS][DATA_WIDTH]  write data, one lane per bank
- s_rvalid  out  [NUM_SLOTS]  read return pulse
- s_rdata  out  [NUM_SLOTS][NUM_BANKS][DATA_WIDTH]  read return data
- ram_en  out  [NUM_BANKS]  bank enable
- ram_we  out  [NUM_BANKS]  bank write enable
- ram_addr  out  [NUM_BANKS][ADDR_WIDTH]  bank address
- ram_wdata  out  [NUM_BANKS][DATA_WIDTH]  bank write data
- ram_rdata  in  [NUM_BANKS][DATA_WIDTH]  bank read data

## Operation
- Eligibility: slot i eligible when s_valid[i] && (!s_rw[i] || s_wvalid[i]); write cmd and data always accepted together.
- Grant: one eligible slot per cycle, round-robin; pointer = slot after last accepted one, updated only on acceptance; reset pointer = 0.
- s_ready[g] = 1 combinationally for granted slot g only; s_wready[g] = s_ready[g] && s_rw[g]; all others 0.
- Accepted command registered into RAM stage: ram_en = mask, ram_we = mask if write else 0, ram_addr replicated to masked banks, ram_wdata = lane data. Unmasked banks: en/we = 0, addr/wdata = 0.
- Read tag pipeline: {valid, slot id, mask} shifted RAM_LATENCY+1 stages from acceptance; at output, s_rdata[slot] captured with ram_rdata on masked lanes, 0 on unmasked lanes; s_rvalid[slot] pulses 1 cycle. No return backpressure.
- s_rdata holds last returned value until next return to that slot.
- mask = 0: accepted, no bank enabled; read still returns s_rvalid with all-zero rdata; write is a no-op.
- Reads and writes interleave freely; read returns stay in acceptance order.
- Reset (any time): RAM stage and tag pipeline cleared, in-flight reads dropped (no s_rvalid), pointer = 0.

## Timing
- Reset values: s_ready, s_wready, s_rvalid, ram_en, ram_we = 0; ram_addr, ram_wdata, s_rdata = 0.
- Acceptance at edge E0 (s_valid && s_ready high) → ram_en high in cycle E0..E1.
- Read: s_rvalid high in cycle after edge E0+RAM_LATENCY+2; with RAM_LATENCY=2, four cycles after acceptance.
- Throughput: one command per cycle, back-to-back from the same or different slots.
- Slot that drops s_valid before grant is simply not granted; no state retained.

## Configuration
- BANK_ARB_FIXED_PRIO_EN defined: fixed priority, lowest slot index wins; pointer logic removed.
- Undefined (default): round-robin as above.

## Structure
- Package bank_arb_pkg: mask_t, addr_t, data_t, lane-array typedef, read-tag struct {valid, slot, mask}, localparam SLOT_W = max(1, $clog2(NUM_SLOTS)).
- Sub-module bank_rr_grant: NUM_SLOTS-wide request → one-hot grant plus pointer register, honours BANK_ARB_FIXED_PRIO_EN.

## Test plan
- Slot 0 writes mask 5'b11111 addr 10 data 0xAAAA0000+k, then reads → s_rvalid[0] exactly 4 cycles after read acceptance, lanes 0xAAAA0000..0xAAAA0004.
- Slot 1 writes mask 5'b00001 addr 50 data 0xCCCC0000, reads mask 5'b00001 → lane0 0xCCCC0000, lanes 1-4 = 0; only ram_en[0] pulses.
- Both slots valid writes (addr 100 / 200) same cycle after reset → slot 0 ready first cycle, slot 1 next cycle; with BANK_ARB_FIXED_PRIO_EN and slot 0 held valid, slot 1 never granted.
- Slot 0 s_valid write with s_wvalid = 0 for 3 cycles while slot 1 reads → slot 1 granted, slot 0 s_ready = 0 until wvalid rises.
- Back-to-back reads slot0 addr 10, slot1 addr 50, slot0 addr 10 → three s_rvalid pulses on consecutive cycles in that order, correct slot routing.
- Read accepted, rst asserted 1 cycle later → no s_rvalid afterwards, all outputs 0 during reset, pointer back to slot 0.
